dinorun_game_ctrl: RTL and testbench



---
 rtl/dinorun_pkg.sv | 27 ++
 rtl/dinorun_game_ctrl_if.sv | 26 ++
 rtl/dinorun_bcd_counter.sv | 48 ++++
 rtl/dinorun_game_ctrl.sv | 110 +++++++++++
 tb/tb_dinorun_game_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dinorun_pkg.sv
// rtl/dinorun_pkg.sv - shared dino runner types, defaults and the score-to-speed mapping.
package dinorun_pkg;

  typedef enum logic [1:0] {
    STARTING = 2'b00,
    PLAYING  = 2'b01,
    HIT      = 2'b10
  } state_t;

  localparam int FramesPerPointDef = 6;
  localparam int HitHoldFramesDef  = 60;
  localparam int BcdScoreWidth     = 16;
  localparam int MaxSpeed          = 7;
  localparam int BaseSpeed         = 2;

  // Hundreds digit adds one pixel per frame; any thousands digit pins the maximum.
  function automatic logic [2:0] speed_from_score(input logic [BcdScoreWidth-1:0] score);
    if (score[15:12] != 4'd0) begin
      return 3'(MaxSpeed);
    end else if (score[11:8] >= 4'(MaxSpeed - BaseSpeed)) begin
      return 3'(MaxSpeed);
    end else begin
      return 3'(BaseSpeed) + score[10:8];
    end
  endfunction

endpackage

// File: rtl/dinorun_game_ctrl_if.sv
// rtl/dinorun_game_ctrl_if.sv - game controller inputs from button/collision logic and outputs to movers/display.
interface dinorun_game_ctrl_if;
  import dinorun_pkg::*;

  logic                     next_frame_i;
  logic                     start_i;
  logic                     collision_i;
  logic [1:0]               state_o;
  logic                     title_en_o;
  logic                     obstacle_en_o;
  logic                     freeze_o;
  logic [BcdScoreWidth-1:0] score_o;
  logic [BcdScoreWidth-1:0] high_score_o;
  logic [2:0]               speed_o;

  modport slave (
    input  next_frame_i, start_i, collision_i,
    output state_o, title_en_o, obstacle_en_o, freeze_o, score_o, high_score_o, speed_o
  );

  modport master (
    output next_frame_i, start_i, collision_i,
    input  state_o, title_en_o, obstacle_en_o, freeze_o, score_o, high_score_o, speed_o
  );

endinterface

// File: rtl/dinorun_bcd_counter.sv
// rtl/dinorun_bcd_counter.sv - 4-digit BCD counter with clear, increment enable and saturation at 9999.
module dinorun_bcd_counter
  import dinorun_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [BcdScoreWidth-1:0] count_o,
  output logic [BcdScoreWidth-1:0] count_d_o
);

  logic [BcdScoreWidth-1:0] count_q;
  logic [BcdScoreWidth-1:0] count_d;
  logic                     carry;

  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != 16'h9999)) begin
      // Ripple the carry digit by digit; a 9 rolls to 0 and passes it on.
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/dinorun_game_ctrl.sv
// rtl/dinorun_game_ctrl.sv - STARTING/PLAYING/HIT sequencer with BCD score, high score and speed level.
module dinorun_game_ctrl
  import dinorun_pkg::*;
#(
  parameter int FramesPerPoint = FramesPerPointDef,
  parameter int HitHoldFrames  = HitHoldFramesDef
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dinorun_game_ctrl_if.slave  gif
);

  state_t                   state_q;
  logic                     start_q;
  logic [5:0]               frame_q;
  logic [7:0]               hold_q;
  logic [BcdScoreWidth-1:0] high_q;
  logic [2:0]               speed_q;
  logic                     title_q;
  logic                     obstacle_q;
  logic                     freeze_q;

  logic                     start_rise;
  logic                     frame_tick;
  logic                     hold_done;
  logic                     go_play;
  logic                     score_inc;
  logic [BcdScoreWidth-1:0] score;
  logic [BcdScoreWidth-1:0] score_d;

  assign start_rise = gif.start_i & ~start_q;
  assign frame_tick = gif.next_frame_i && (frame_q == 6'(FramesPerPoint - 1));
  assign hold_done  = (hold_q == 8'(HitHoldFrames));
  assign go_play    = start_rise && ((state_q == STARTING) || ((state_q == HIT) && hold_done));
  // A collision on the scoring frame ends the game without awarding the point.
  assign score_inc  = (state_q == PLAYING) && frame_tick && !gif.collision_i;

  dinorun_bcd_counter u_score (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (go_play),
    .inc_i     (score_inc),
    .count_o   (score),
    .count_d_o (score_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= STARTING;
      start_q    <= 1'b1;
      frame_q    <= '0;
      hold_q     <= '0;
      high_q     <= '0;
      speed_q    <= 3'(BaseSpeed);
      title_q    <= 1'b1;
      obstacle_q <= 1'b0;
      freeze_q   <= 1'b0;
    end else begin
      start_q <= gif.start_i;
      speed_q <= speed_from_score(score_d);
      case (state_q)
        STARTING: begin
          if (go_play) begin
            state_q    <= PLAYING;
            frame_q    <= '0;
            title_q    <= 1'b0;
            obstacle_q <= 1'b1;
            freeze_q   <= 1'b0;
          end
        end
        PLAYING: begin
          if (gif.collision_i) begin
            state_q  <= HIT;
            hold_q   <= '0;
            freeze_q <= 1'b1;
            if (score > high_q) begin
              high_q <= score;
            end
          end else if (gif.next_frame_i) begin
            frame_q <= frame_tick ? 6'd0 : frame_q + 6'd1;
          end
        end
        HIT: begin
          if (go_play) begin
            state_q  <= PLAYING;
            frame_q  <= '0;
            freeze_q <= 1'b0;
          end else if (gif.next_frame_i && !hold_done) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q    <= STARTING;
          title_q    <= 1'b1;
          obstacle_q <= 1'b0;
          freeze_q   <= 1'b0;
        end
      endcase
    end
  end

  assign gif.state_o       = state_q;
  assign gif.title_en_o    = title_q;
  assign gif.obstacle_en_o = obstacle_q;
  assign gif.freeze_o      = freeze_q;
  assign gif.score_o       = score;
  assign gif.high_score_o  = high_q;
  assign gif.speed_o       = speed_q;

endmodule

// File: tb/tb_dinorun_game_ctrl.sv
// tb/tb_dinorun_game_ctrl.sv - scoreboard bench for the dino runner game controller.
module tb_dinorun_game_ctrl;
  import dinorun_pkg::*;

  typedef struct packed {
    logic [1:0]  st;
    logic        title;
    logic        obst;
    logic        frz;
    logic [15:0] score;
    logic [15:0] hi;
    logic [2:0]  spd;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  obs_t  exp_q[$];
  string nm_q[$];
  obs_t  got;
  obs_t  e;
  string n;
  int    vectors     = 0;
  int    miscompares = 0;

  dinorun_game_ctrl_if gif ();

  dinorun_game_ctrl #(
    .FramesPerPoint (6),
    .HitHoldFrames  (60)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .gif    (gif)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] st, input logic [15:0] score,
                              input logic [15:0] hi, input logic [2:0] spd);
    obs_t o;
    o.st    = st;
    o.title = (st == STARTING);
    o.obst  = (st != STARTING);
    o.frz   = (st == HIT);
    o.score = score;
    o.hi    = hi;
    o.spd   = spd;
    return o;
  endfunction

  function automatic obs_t sample();
    return {gif.state_o, gif.title_en_o, gif.obstacle_en_o, gif.freeze_o,
            gif.score_o, gif.high_score_o, gif.speed_o};
  endfunction

  function automatic string show(input obs_t o);
    return $sformatf("st=%0d title=%0b obst=%0b frz=%0b score=%h hi=%h spd=%0d",
                     o.st, o.title, o.obst, o.frz, o.score, o.hi, o.spd);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frames(input int count);
    for (int i = 0; i < count; i++) begin
      gif.next_frame_i = 1'b1;
      cyc();
    end
    gif.next_frame_i = 1'b0;
  endtask

  task automatic press_start();
    gif.start_i = 1'b0;
    cyc();
    gif.start_i = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    gif.start_i      = 1'b1;
    gif.next_frame_i = 1'b0;
    gif.collision_i  = 1'b0;
    rst_n            = 1'b0;
    for (int step = 0; step < 3; step++) begin
      if (step == 0) begin
        exp_q.push_back(mk(STARTING, 16'h0000, 16'h0000, 3'd2));
        nm_q.push_back("reset_values");
        cyc();
        cyc();
      end else if (step == 1) begin
        exp_q.push_back(mk(STARTING, 16'h0000, 16'h0000, 3'd2));
        nm_q.push_back("held_start_ignored");
        rst_n = 1'b1;
        cyc();
        cyc();
        cyc();
        gif.start_i = 1'b0;
        cyc();
      end else begin
        exp_q.push_back(mk(PLAYING, 16'h0000, 16'h0000, 3'd2));
        nm_q.push_back("second_edge_plays");
        gif.start_i = 1'b1;
        cyc();
      end
      got = sample();
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got %s required %s", n, show(got), show(e));
      end
    end
  endtask

  task automatic test_score();
    int          nfr[8] = '{12, 582, 6, 5, 3589, 6, 55794, 6};
    logic [15:0] es[8]  = '{16'h0002, 16'h0099, 16'h0100, 16'h0100,
                            16'h0699, 16'h0700, 16'h9999, 16'h9999};
    logic [2:0]  sp[8]  = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7, 3'd7};
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(mk(PLAYING, es[k], 16'h0000, sp[k]));
      nm_q.push_back($sformatf("score_step%0d", k));
      run_frames(nfr[k]);
      got = sample();
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got %s required %s", n, show(got), show(e));
      end
    end
  endtask

  task automatic test_async_reset(input string tag);
    exp_q.push_back(mk(STARTING, 16'h0000, 16'h0000, 3'd2));
    nm_q.push_back(tag);
    #2;
    rst_n = 1'b0;
    #1;
    got = sample();
    e   = exp_q.pop_front();
    n   = nm_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s: got %s required %s", n, show(got), show(e));
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_collision();
    for (int step = 0; step < 2; step++) begin
      if (step == 0) begin
        exp_q.push_back(mk(PLAYING, 16'h0041, 16'h0000, 3'd2));
        nm_q.push_back("reach_0041");
        press_start();
        run_frames(246);
      end else begin
        exp_q.push_back(mk(HIT, 16'h0041, 16'h0041, 3'd2));
        nm_q.push_back("collision_beats_tick");
        run_frames(5);
        gif.next_frame_i = 1'b1;
        gif.collision_i  = 1'b1;
        cyc();
        gif.next_frame_i = 1'b0;
        gif.collision_i  = 1'b0;
      end
      got = sample();
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got %s required %s", n, show(got), show(e));
      end
    end
  endtask

  task automatic test_hit_hold();
    for (int step = 0; step < 2; step++) begin
      if (step == 0) begin
        exp_q.push_back(mk(HIT, 16'h0041, 16'h0041, 3'd2));
        nm_q.push_back("hold_59_ignores_start");
        gif.start_i = 1'b0;
        run_frames(59);
        gif.start_i = 1'b1;
        cyc();
      end else begin
        exp_q.push_back(mk(PLAYING, 16'h0000, 16'h0041, 3'd2));
        nm_q.push_back("hold_60_restarts");
        gif.start_i = 1'b0;
        run_frames(1);
        gif.start_i = 1'b1;
        cyc();
      end
      got = sample();
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got %s required %s", n, show(got), show(e));
      end
    end
  endtask

  task automatic test_second_game();
    for (int step = 0; step < 4; step++) begin
      if (step == 0) begin
        exp_q.push_back(mk(HIT, 16'h0030, 16'h0041, 3'd2));
        nm_q.push_back("lower_score_keeps_high");
        run_frames(180);
        gif.collision_i = 1'b1;
        cyc();
        gif.collision_i = 1'b0;
      end else if (step == 1) begin
        exp_q.push_back(mk(HIT, 16'h0030, 16'h0041, 3'd2));
        nm_q.push_back("hit_holds_score");
        run_frames(20);
      end else if (step == 2) begin
        exp_q.push_back(mk(PLAYING, 16'h0000, 16'h0041, 3'd2));
        nm_q.push_back("third_game_start");
        gif.start_i = 1'b0;
        run_frames(60);
        gif.start_i = 1'b1;
        cyc();
      end else begin
        exp_q.push_back(mk(PLAYING, 16'h0001, 16'h0041, 3'd2));
        nm_q.push_back("third_game_scores");
        run_frames(10);
      end
      got = sample();
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got %s required %s", n, show(got), show(e));
      end
    end
  endtask

  initial begin
    gif.start_i      = 1'b1;
    gif.next_frame_i = 1'b0;
    gif.collision_i  = 1'b0;
    test_reset();
    test_score();
    test_async_reset("reset_after_saturation");
    test_collision();
    test_hit_hold();
    test_second_game();
    test_async_reset("reset_mid_play_clears_high");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
